// File: rtl/sseg_scan_if.sv
// Bus between the door-lock controller and the seven-segment scan driver.
// The controller drives packed BCD digits, display mode and blink; the driver returns seg/an.
interface sseg_scan_if #(
    parameter int unsigned N_DIGITS = 4
);
    logic [4*N_DIGITS-1:0] digits_in;
    logic [1:0]            mode_in;
    logic                  blink_en;
    logic [6:0]            seg;
    logic [N_DIGITS-1:0]   an;

    modport master (
        output digits_in, mode_in, blink_en,
        input  seg, an
    );

    modport slave (
        input  digits_in, mode_in, blink_en,
        output seg, an
    );
endinterface

// File: rtl/sseg_scan.sv
// Time-multiplexed N-digit seven-segment driver with frame-coherent capture and blinking.
// Optional leading-zero blanking is enabled by defining SSEG_SCAN_LZB_EN.
module sseg_scan #(
    parameter int unsigned N_DIGITS    = 4,
    parameter int unsigned SCAN_DIV    = 1000,
    parameter int unsigned BLINK_TICKS = 250
) (
    input  logic        clk,
    input  logic        reset,
    sseg_scan_if.slave  bus
);
    localparam int unsigned PW = $clog2(SCAN_DIV);
    localparam int unsigned IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    logic [PW-1:0]         presc;
    logic [IW-1:0]         idx;
    logic [4*N_DIGITS-1:0] frame_buf;
    logic [1:0]            mode_q;
    logic [BW-1:0]         bcnt;
    logic                  phase;
    logic [6:0]            seg_q;
    logic [N_DIGITS-1:0]   an_q;
`ifdef SSEG_SCAN_LZB_EN
    logic [N_DIGITS-1:0]   lzb_q;
`endif

    logic                tick;
    logic                last_digit;
    logic [3:0]          cur_digit;
    logic                digit_blank;
    logic [6:0]          seg_d;
    logic [N_DIGITS-1:0] an_d;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7C;
            4'd7:    return 7'h27;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

`ifdef SSEG_SCAN_LZB_EN
    // A zero is blanked only while every more-significant digit is zero or non-BCD.
    function automatic logic [N_DIGITS-1:0] lzb_mask(input logic [4*N_DIGITS-1:0] d);
        logic [N_DIGITS-1:0] m;
        logic                higher;
        logic [3:0]          v;
        m      = '0;
        higher = 1'b1;
        for (int k = int'(N_DIGITS) - 1; k >= 1; k--) begin
            v      = d[4*k +: 4];
            m[k]   = higher && (v == 4'd0);
            higher = higher && ((v == 4'd0) || (v > 4'd9));
        end
        return m;
    endfunction
`endif

    always_comb begin
        tick       = (presc == PW'(SCAN_DIV - 1));
        last_digit = (idx == IW'(N_DIGITS - 1));
        cur_digit  = frame_buf[4*int'(idx) +: 4];
`ifdef SSEG_SCAN_LZB_EN
        digit_blank = lzb_q[idx];
`else
        digit_blank = 1'b0;
`endif
        if (mode_q == 2'b01 || mode_q == 2'b10) begin
            seg_d = digit_blank ? 7'h00 : decode(cur_digit);
        end else begin
            seg_d = 7'h40;
        end
        an_d = '0;
        // Gating on the live blink_en lets the display reappear the cycle after blink drops.
        if (!(phase && bus.blink_en)) begin
            an_d[idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc     <= '0;
            idx       <= '0;
            frame_buf <= '1;
            mode_q    <= 2'b00;
            bcnt      <= '0;
            phase     <= 1'b0;
            seg_q     <= 7'h40;
            an_q      <= '0;
`ifdef SSEG_SCAN_LZB_EN
            lzb_q     <= '0;
`endif
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) begin
                idx <= last_digit ? '0 : idx + IW'(1);
                if (last_digit) begin
                    frame_buf <= bus.digits_in;
                    mode_q    <= bus.mode_in;
`ifdef SSEG_SCAN_LZB_EN
                    lzb_q     <= lzb_mask(bus.digits_in);
`endif
                end
            end
            if (!bus.blink_en) begin
                bcnt  <= '0;
                phase <= 1'b0;
            end else if (tick) begin
                if (bcnt == BW'(BLINK_TICKS - 1)) begin
                    bcnt  <= '0;
                    phase <= ~phase;
                end else begin
                    bcnt <= bcnt + BW'(1);
                end
            end
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign bus.seg = seg_q;
    assign bus.an  = an_q;
endmodule
